// File: rtl/lenet_pkg.sv
// rtl/lenet_pkg.sv - shared LeNet constants and window sequencer state encoding
package lenet_pkg;

    localparam int LENET_TAPS       = 25;
    localparam int LENET_DATA_WIDTH = 8;
    localparam int LENET_RES_WIDTH  = 8;
    localparam int LENET_ACC_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } win_state_e;

endpackage

// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - unsigned accumulator that clamps at all-ones instead of wrapping
module sat_accumulator #(
    parameter int ADD_WIDTH = 8,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [ADD_WIDTH-1:0] addend_i,
    output logic [ACC_WIDTH-1:0] sum_o
);

    logic [ACC_WIDTH-1:0] sum_q;
    logic [ACC_WIDTH-1:0] sum_d;
    logic [ACC_WIDTH:0]   wide_sum;

    // One guard bit catches the carry out; a set carry means the result overflowed.
    assign wide_sum = {1'b0, sum_q} + {{(ACC_WIDTH + 1 - ADD_WIDTH){1'b0}}, addend_i};

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (en_i) begin
            sum_d = wide_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide_sum[ACC_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mac_window_sequencer.sv
// rtl/mac_window_sequencer.sv - walks one convolution window through an external Mac
// and returns the saturated window sum over a valid/ready handshake.
module mac_window_sequencer
    import lenet_pkg::*;
#(
    parameter int DATA_WIDTH = LENET_DATA_WIDTH,
    parameter int RES_WIDTH  = LENET_RES_WIDTH,
    parameter int ACC_WIDTH  = LENET_ACC_WIDTH,
    parameter int TAPS       = LENET_TAPS,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  busy,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] feat_rdata,
    input  logic [DATA_WIDTH-1:0] weight_rdata,
    output logic [DATA_WIDTH-1:0] mac_data,
    output logic [DATA_WIDTH-1:0] mac_weight,
    output logic [DATA_WIDTH-1:0] mac_bias,
    input  logic [RES_WIDTH-1:0]  mac_res,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_TAP = ADDR_WIDTH'(TAPS - 1);

    win_state_e            state_q;
    logic [ADDR_WIDTH-1:0] tap_q;
    logic                  rd_en_q;
    logic                  acc_en_q;
    logic                  first_q;
    logic                  busy_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] bias_q;

    logic                  acc_clear;
    logic [ACC_WIDTH-1:0]  acc_sum;

    assign acc_clear = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            rd_en_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            first_q     <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            bias_q      <= '0;
        end else begin
            // Read data lands one cycle after the strobe, so accumulation trails it by one.
            acc_en_q <= rd_en_q;
            if (acc_en_q) begin
                first_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_FETCH;
                        bias_q  <= bias;
                        tap_q   <= '0;
                        rd_en_q <= 1'b1;
                        first_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (tap_q == LAST_TAP) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                        tap_q   <= '0;
                    end else begin
                        tap_q <= tap_q + ADDR_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    state_q     <= ST_DONE;
                    out_valid_q <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sat_accumulator #(
        .ADD_WIDTH(RES_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) u_acc (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (acc_clear),
        .en_i     (acc_en_q),
        .addend_i (mac_res),
        .sum_o    (acc_sum)
    );

    // Bias enters the Mac on the first tap only so it is counted once per window.
    assign mac_data   = acc_en_q ? feat_rdata : '0;
    assign mac_weight = acc_en_q ? weight_rdata : '0;
    assign mac_bias   = (acc_en_q && first_q) ? bias_q : '0;

    assign busy      = busy_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = tap_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? acc_sum : '0;

endmodule

// File: tb/tb_mac_window_sequencer.sv
// tb/tb_mac_window_sequencer.sv - bench for mac_window_sequencer (16-bit and 12-bit accumulators)
module tb_mac_window_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       out_ready;
    logic [7:0] bias;

    logic       busy_a, rd_en_a, out_valid_a;
    logic [4:0] rd_addr_a;
    logic [7:0] feat_a, wt_a, mac_data_a, mac_weight_a, mac_bias_a, mac_res_a;
    logic [15:0] out_data_a;

    logic       busy_b, rd_en_b, out_valid_b;
    logic [4:0] rd_addr_b;
    logic [7:0] feat_b, wt_b, mac_data_b, mac_weight_b, mac_bias_b, mac_res_b;
    logic [11:0] out_data_b;

    logic [7:0] feat_mem [25];
    logic [7:0] wt_mem   [25];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_window_sequencer u_dut16 (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .feat_rdata(feat_a), .weight_rdata(wt_a),
        .mac_data(mac_data_a), .mac_weight(mac_weight_a), .mac_bias(mac_bias_a),
        .mac_res(mac_res_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready)
    );

    mac_window_sequencer #(.ACC_WIDTH(12)) u_dut12 (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .busy(busy_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .feat_rdata(feat_b), .weight_rdata(wt_b),
        .mac_data(mac_data_b), .mac_weight(mac_weight_b), .mac_bias(mac_bias_b),
        .mac_res(mac_res_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready)
    );

    // Mac stub: (data * weight + bias) mod 256
    always_comb begin
        mac_res_a = 8'((32'(mac_data_a) * 32'(mac_weight_a) + 32'(mac_bias_a)) % 256);
        mac_res_b = 8'((32'(mac_data_b) * 32'(mac_weight_b) + 32'(mac_bias_b)) % 256);
    end

    // Synchronous-read operand memories, one cycle latency
    always @(posedge clk) begin
        if (rd_en_a) begin
            feat_a <= feat_mem[rd_addr_a];
            wt_a   <= wt_mem[rd_addr_a];
        end
        if (rd_en_b) begin
            feat_b <= feat_mem[rd_addr_b];
            wt_b   <= wt_mem[rd_addr_b];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int model_sum(input int cap, input int b);
        int s = 0;
        for (int i = 0; i < 25; i++) begin
            s += (int'(feat_mem[i]) * int'(wt_mem[i]) + ((i == 0) ? b : 0)) % 256;
        end
        return (s > cap) ? cap : s;
    endfunction

    task automatic run_window(input int b, output int lat, output int d16, output int d12,
                              output int rd_cnt, output int addr_err, output int vcyc);
        lat = 0; d16 = -1; d12 = -1; rd_cnt = 0; addr_err = 0; vcyc = 0;
        @(posedge clk); #1;
        start = 1'b1;
        bias  = 8'(b);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < 100; c++) begin
            @(negedge clk);
            if (rd_en_a) begin
                if (int'(rd_addr_a) != rd_cnt || rd_en_b !== 1'b1) addr_err++;
                rd_cnt++;
            end
            if (out_valid_a) begin
                lat  = c;
                d16  = int'(out_data_a);
                d12  = out_valid_b ? int'(out_data_b) : -1;
                vcyc = cyc;
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic finish_hs(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_busy_after_hs"}, int'(busy_a), 0);
        chk({tag, "_valid_after_hs"}, int'(out_valid_a), 0);
    endtask

    task automatic load_const(input int f, input int w, input bit ramp);
        for (int i = 0; i < 25; i++) begin
            feat_mem[i] = ramp ? 8'(i) : 8'(f);
            wt_mem[i]   = 8'(w);
        end
    endtask

    typedef struct {
        string name;
        int    fval;
        int    wval;
        int    b;
        bit    ramp;
        int    exp16;
        int    exp12;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, d16, d12, rd_cnt, addr_err, vcyc, prev_vcyc, e16, e12, b;

        vecs[0] = '{"basic_2x3_b7",  2,   3,   7, 1'b0, 157,  157};
        vecs[1] = '{"sat_15x17",    15,  17,   0, 1'b0, 6375, 4095};
        vecs[2] = '{"ramp_w1",       0,   1,   0, 1'b1, 300,  300};
        vecs[3] = '{"ones",          1,   1,   0, 1'b0, 25,   25};
        vecs[4] = '{"wrap_16x16_b5", 16,  16,  5, 1'b0, 5,    5};
        vecs[5] = '{"max_255x255",  255, 255,  0, 1'b0, 25,   25};

        rst = 1'b1; start = 1'b0; out_ready = 1'b1; bias = 8'd0;
        load_const(0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_rd_en", int'(rd_en_a), 0);
        chk("rst_rd_addr", int'(rd_addr_a), 0);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_out_data", int'(out_data_a), 0);
        chk("rst_mac_bias", int'(mac_bias_a), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            load_const(vecs[v].fval, vecs[v].wval, vecs[v].ramp);
            run_window(vecs[v].b, lat, d16, d12, rd_cnt, addr_err, vcyc);
            chk({vecs[v].name, "_latency"}, lat, 27);
            chk({vecs[v].name, "_sum16"}, d16, vecs[v].exp16);
            chk({vecs[v].name, "_sum12"}, d12, vecs[v].exp12);
            chk({vecs[v].name, "_rd_cycles"}, rd_cnt, 25);
            chk({vecs[v].name, "_addr_seq_errs"}, addr_err, 0);
            finish_hs(vecs[v].name);
        end

        // Backpressure in DONE with start pulses that must be ignored
        load_const(2, 3, 1'b0);
        out_ready = 1'b0;
        run_window(7, lat, d16, d12, rd_cnt, addr_err, vcyc);
        chk("bp_latency", lat, 27);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            start = k[0];
            @(negedge clk);
            chk("bp_valid_held", int'(out_valid_a), 1);
            chk("bp_data_held", int'(out_data_a), 157);
            chk("bp_rd_en_idle", int'(rd_en_a), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("bp_idle_after_hs", int'(busy_a), 0);
        @(posedge clk);
        @(negedge clk);
        chk("bp_no_new_window", int'(busy_a), 0);
        chk("bp_no_rd_en", int'(rd_en_a), 0);

        // Reset asserted during the 10th FETCH cycle
        load_const(1, 1, 1'b0);
        @(posedge clk); #1;
        start = 1'b1; bias = 8'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_rd_addr_before_rst", int'(rd_addr_a), 9);
        chk("mid_mac_data_before_rst", int'(mac_data_a), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy_a), 0);
        chk("mid_rst_rd_en", int'(rd_en_a), 0);
        chk("mid_rst_rd_addr", int'(rd_addr_a), 0);
        chk("mid_rst_out_valid", int'(out_valid_a), 0);
        chk("mid_rst_out_data", int'(out_data_a), 0);
        chk("mid_rst_mac_data", int'(mac_data_a), 0);
        chk("mid_rst_mac_weight", int'(mac_weight_a), 0);
        chk("mid_rst_mac_bias", int'(mac_bias_a), 0);
        @(negedge clk);
        rst = 1'b0;
        run_window(0, lat, d16, d12, rd_cnt, addr_err, vcyc);
        chk("post_rst_latency", lat, 27);
        chk("post_rst_sum", d16, 25);
        finish_hs("post_rst");

        // Back-to-back randomized windows against the reference model
        prev_vcyc = 0;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 25; i++) begin
                feat_mem[i] = 8'($urandom_range(0, 255));
                wt_mem[i]   = 8'($urandom_range(0, 255));
            end
            b   = int'($urandom_range(0, 255));
            e16 = model_sum(65535, b);
            e12 = model_sum(4095, b);
            run_window(b, lat, d16, d12, rd_cnt, addr_err, vcyc);
            chk("rand_latency", lat, 27);
            chk("rand_sum16", d16, e16);
            chk("rand_sum12", d12, e12);
            chk("rand_addr_seq_errs", addr_err, 0);
            if (r > 0) chk("rand_period", vcyc - prev_vcyc, 29);
            prev_vcyc = vcyc;
            @(posedge clk);
            @(negedge clk);
            chk("rand_busy_after_hs", int'(busy_a), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
